cgol_gen_engine: RTL

Parametrised Game of Life generation engine holding a ROWS x COLS grid in on-chip registers, double-buffered. Computes one row of the next generation per cycle, then swaps buffers. Supports single-step and free-running modes, torus or dead-border edges, host row loading, and a combinational row read port for the display scanner. Sits between the host/load logic and dispcontrol, replacing the fixed 8x8 row decode path.

---
 rtl/cgol_pkg.sv | 12 +
 rtl/cgol_row_next.sv | 31 +++
 rtl/cgol_gen_engine.sv | 113 +++++++++++
 3 files changed

// File: rtl/cgol_pkg.sv
// cgol_pkg: FSM encodings and Life rule constants shared by the generation engine.
package cgol_pkg;
    localparam int SUM_W = 4;
    typedef logic [1:0] state_t;
    localparam state_t IDLE    = 2'd0;
    localparam state_t COMPUTE = 2'd1;
    localparam state_t SWAP    = 2'd2;
    localparam state_t HOLD    = 2'd3;
    localparam logic [SUM_W-1:0] BIRTH_COUNT = 4'd3;
    localparam logic [SUM_W-1:0] SURVIVE_MIN = 4'd2;
    localparam logic [SUM_W-1:0] SURVIVE_MAX = 4'd3;
endpackage

// File: rtl/cgol_row_next.sv
// cgol_row_next: next-generation value of one grid row from the rows above, at and below it.
module cgol_row_next
    import cgol_pkg::*;
#(
    parameter int COLS = 8,
    parameter int WRAP = 1
) (
    input  logic [COLS-1:0] above,
    input  logic [COLS-1:0] center,
    input  logic [COLS-1:0] below,
    output logic [COLS-1:0] nxt
);
    logic [COLS+1:0] ea, ec, eb;

    // Pad each row with its wrapped (or dead) edge columns so column c sees bits c..c+2
    function automatic logic [COLS+1:0] ext(input logic [COLS-1:0] r);
        return {WRAP != 0 ? r[0] : 1'b0, r, WRAP != 0 ? r[COLS-1] : 1'b0};
    endfunction

    assign ea = ext(above);
    assign ec = ext(center);
    assign eb = ext(below);

    for (genvar c = 0; c < COLS; c++) begin : g_col
        logic [SUM_W-1:0] sum;
        assign sum = SUM_W'(ea[c]) + SUM_W'(ea[c+1]) + SUM_W'(ea[c+2])
                   + SUM_W'(ec[c]) + SUM_W'(ec[c+2])
                   + SUM_W'(eb[c]) + SUM_W'(eb[c+1]) + SUM_W'(eb[c+2]);
        assign nxt[c] = sum == BIRTH_COUNT || (ec[c+1] && sum >= SURVIVE_MIN && sum <= SURVIVE_MAX);
    end
endmodule

// File: rtl/cgol_gen_engine.sv
// cgol_gen_engine: double-buffered Game of Life engine computing one row per cycle.
// Define CGOL_STILL_DETECT_EN to add the still output that halts run mode on a still life.
module cgol_gen_engine
    import cgol_pkg::*;
#(
    parameter int COLS   = 8,
    parameter int ROWS   = 8,
    parameter int WRAP   = 1,
    parameter int GEN_W  = 16,
    parameter int HOLD_W = 6
) (
    input  logic                    ph1,
    input  logic                    reset,
    input  logic                    load_en,
    input  logic [$clog2(ROWS)-1:0] load_addr,
    input  logic [COLS-1:0]         load_row,
    input  logic                    step,
    input  logic                    run,
    input  logic [HOLD_W-1:0]       hold_cycles,
    input  logic [$clog2(ROWS)-1:0] rd_addr,
    output logic [COLS-1:0]         rd_row,
    output logic                    busy,
    output logic                    gen_done,
    output logic [GEN_W-1:0]        gen_count
`ifdef CGOL_STILL_DETECT_EN
    ,
    output logic                    still
`endif
);
    localparam int AW = $clog2(ROWS);
    localparam logic [AW:0] ROWS_V = (AW+1)'(ROWS);

    logic [COLS-1:0] front [ROWS];
    logic [COLS-1:0] back  [ROWS];
    state_t          state;
    logic [AW-1:0]   ptr;
    logic [HOLD_W-1:0] hold;
    logic [COLS-1:0] above, below, nxt;
    logic            last, load_ok, halt;

    assign last    = ptr == AW'(ROWS-1);
    assign load_ok = {1'b0, load_addr} < ROWS_V;
    assign rd_row  = {1'b0, rd_addr} < ROWS_V ? front[rd_addr] : '0;
    assign busy    = state != IDLE;
    assign above   = ptr == '0 ? (WRAP != 0 ? front[ROWS-1] : '0) : front[ptr-AW'(1)];
    assign below   = last ? (WRAP != 0 ? front[0] : '0) : front[ptr+AW'(1)];

    cgol_row_next #(.COLS(COLS), .WRAP(WRAP)) u_row (
        .above(above),
        .center(front[ptr]),
        .below(below),
        .nxt(nxt)
    );

`ifdef CGOL_STILL_DETECT_EN
    logic same;
    always_comb begin
        same = 1'b1;
        for (int i = 0; i < ROWS; i++) same = same && back[i] == front[i];
    end
    assign halt = same;
    always_ff @(posedge ph1 or negedge reset) begin
        if (!reset) still <= 1'b0;
        else if (state == SWAP) still <= same;
        else if (state == IDLE && load_en && load_ok) still <= 1'b0;
    end
`else
    assign halt = 1'b0;
`endif

    always_ff @(posedge ph1 or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ROWS; i++) begin
                front[i] <= '0;
                back[i]  <= '0;
            end
            state     <= IDLE;
            ptr       <= '0;
            hold      <= '0;
            gen_count <= '0;
            gen_done  <= 1'b0;
        end else begin
            gen_done <= state == SWAP;
            case (state)
                IDLE: begin
                    if (load_en) begin
                        if (load_ok) front[load_addr] <= load_row;
                    end else if (step || run) begin
                        state <= COMPUTE;
                        ptr   <= '0;
                    end
                end
                COMPUTE: begin
                    back[ptr] <= nxt;
                    ptr       <= ptr + AW'(1);
                    if (last) state <= SWAP;
                end
                SWAP: begin
                    front     <= back;
                    gen_count <= gen_count + GEN_W'(1);
                    hold      <= hold_cycles;
                    ptr       <= '0;
                    state     <= !run || halt ? IDLE : hold_cycles != '0 ? HOLD : COMPUTE;
                end
                default: begin
                    hold  <= hold - HOLD_W'(1);
                    ptr   <= '0;
                    state <= !run ? IDLE : hold == HOLD_W'(1) ? COMPUTE : HOLD;
                end
            endcase
        end
    end
endmodule
